// File: rtl/mips_pkg.sv
// Shared encodings and default widths for the 32-bit pipelined MIPS core.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_SLL  = 2'b01,
        SH_SRL  = 2'b10,
        SH_SRA  = 2'b11
    } shift_sel_t;

    typedef enum logic {
        RES_ALU   = 1'b0,
        RES_SHIFT = 1'b1
    } res_sel_t;

endpackage

// File: rtl/ex_result_mux.sv
// EX-stage result select: ALU output or one of the four barrel-shifter outputs.
module ex_result_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              res_sel,
    input  logic [1:0]        shift_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] no_shift,
    input  logic [DATA_W-1:0] logic_left,
    input  logic [DATA_W-1:0] logic_right,
    input  logic [DATA_W-1:0] arith_right,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shift_result;

    always_comb begin
        shift_result = no_shift;
        case (shift_sel)
            SH_NONE: shift_result = no_shift;
            SH_SLL:  shift_result = logic_left;
            SH_SRL:  shift_result = logic_right;
            SH_SRA:  shift_result = arith_right;
            default: shift_result = no_shift;
        endcase
    end

    assign result = (res_sel == RES_SHIFT) ? shift_result : alu_result;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush, illegal-control flag and forwarding decode.
// Optional stall counter is built only when PERF_CNT_EN is defined.
module ex_mem_reg
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              res_sel,
    input  logic [1:0]        shift_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] no_shift,
    input  logic [DATA_W-1:0] logic_left,
    input  logic [DATA_W-1:0] logic_right,
    input  logic [DATA_W-1:0] arith_right,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_W-1:0]  dest_reg,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    output logic              out_valid,
    output logic [DATA_W-1:0] ex_result,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_W-1:0]  out_dest_reg,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_mem_to_reg,
    output logic              fwd_en,
    output logic              illegal_op
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    logic [DATA_W-1:0] sel_result;
    logic              is_illegal;
    logic              load_ok;

    ex_result_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .res_sel     (res_sel),
        .shift_sel   (shift_sel),
        .alu_result  (alu_result),
        .no_shift    (no_shift),
        .logic_left  (logic_left),
        .logic_right (logic_right),
        .arith_right (arith_right),
        .result      (sel_result)
    );

    assign is_illegal = in_valid & mem_read & mem_write;
    assign load_ok    = in_valid & ~is_illegal;

    // Bubbles and illegal instructions still capture data; only valid and controls are killed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid      <= 1'b0;
            ex_result      <= '0;
            store_data     <= '0;
            out_dest_reg   <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
            illegal_op     <= 1'b0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_mem_to_reg <= 1'b0;
        end else if (!stall) begin
            ex_result      <= sel_result;
            store_data     <= rt_data;
            out_dest_reg   <= dest_reg;
            out_valid      <= load_ok;
            out_reg_write  <= load_ok & reg_write & (dest_reg != '0);
            out_mem_read   <= load_ok & mem_read;
            out_mem_write  <= load_ok & mem_write;
            out_mem_to_reg <= load_ok & mem_to_reg;
            if (is_illegal) begin
                illegal_op <= 1'b1;
            end
        end
    end

    assign fwd_en = out_valid & out_reg_write & (out_dest_reg != '0);

`ifdef PERF_CNT_EN
    // Counts cycles a real instruction is held by the hazard unit; saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !flush && out_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic vs. a reference model.
module tb_ex_mem_reg;

    logic        clk;
    logic        reset;
    logic        in_valid, stall, flush, res_sel;
    logic [1:0]  shift_sel;
    logic [31:0] alu_result, no_shift, logic_left, logic_right, arith_right, rt_data;
    logic [4:0]  dest_reg;
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        out_valid;
    logic [31:0] ex_result, store_data;
    logic [4:0]  out_dest_reg;
    logic        out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
    logic        fwd_en, illegal_op;
`ifdef PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model state
    logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_ill;
    logic [31:0] m_res, m_store;
    logic [4:0]  m_dest;
    logic [15:0] m_cnt;
    bit          m_data_known;

    ex_mem_reg dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .stall          (stall),
        .flush          (flush),
        .res_sel        (res_sel),
        .shift_sel      (shift_sel),
        .alu_result     (alu_result),
        .no_shift       (no_shift),
        .logic_left     (logic_left),
        .logic_right    (logic_right),
        .arith_right    (arith_right),
        .rt_data        (rt_data),
        .dest_reg       (dest_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .out_valid      (out_valid),
        .ex_result      (ex_result),
        .store_data     (store_data),
        .out_dest_reg   (out_dest_reg),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_mem_to_reg (out_mem_to_reg),
        .fwd_en         (fwd_en),
        .illegal_op     (illegal_op)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_ill = 0;
        m_res = 0; m_store = 0; m_dest = 0; m_cnt = 0; m_data_known = 1;
    endtask

    function automatic logic [31:0] pick_result();
        logic [31:0] sh [4];
        sh[0] = no_shift; sh[1] = logic_left; sh[2] = logic_right; sh[3] = arith_right;
        return res_sel ? sh[shift_sel] : alu_result;
    endfunction

    // One rising edge of the pipeline register, expressed as the priority rules.
    task automatic model_edge();
        bit bad;
        bad = in_valid && mem_read && mem_write;
        if (flush) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
        end else if (stall) begin
            if (m_valid && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        end else begin
            m_res = pick_result(); m_store = rt_data; m_dest = dest_reg;
            m_data_known = !bad;
            if (in_valid && !bad) begin
                m_valid = 1; m_rw = reg_write && (dest_reg != 0);
                m_mr = mem_read; m_mw = mem_write; m_m2r = mem_to_reg;
            end else begin
                m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0;
            end
            if (bad) m_ill = 1;
        end
    endtask

    task automatic check_output();
        check_val("out_valid", out_valid, m_valid);
        if (m_data_known) begin
            check_val("ex_result", ex_result, m_res);
            check_val("store_data", store_data, m_store);
            check_val("out_dest_reg", out_dest_reg, m_dest);
        end
        check_val("out_reg_write", out_reg_write, m_rw);
        check_val("out_mem_read", out_mem_read, m_mr);
        check_val("out_mem_write", out_mem_write, m_mw);
        check_val("out_mem_to_reg", out_mem_to_reg, m_m2r);
        check_val("fwd_en", fwd_en, m_valid && m_rw && (m_dest != 0));
        check_val("illegal_op", illegal_op, m_ill);
`ifdef PERF_CNT_EN
        check_val("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    task automatic apply_stimulus(input bit allow_illegal);
        in_valid    = $urandom_range(0, 3) != 0;
        stall       = $urandom_range(0, 3) == 0;
        flush       = $urandom_range(0, 7) == 0;
        res_sel     = $urandom_range(0, 1);
        shift_sel   = $urandom_range(0, 3);
        alu_result  = $urandom; no_shift = $urandom; logic_left = $urandom;
        logic_right = $urandom; arith_right = $urandom; rt_data = $urandom;
        dest_reg    = $urandom_range(0, 31);
        reg_write   = $urandom_range(0, 1);
        mem_read    = $urandom_range(0, 1);
        mem_write   = $urandom_range(0, 1);
        mem_to_reg  = $urandom_range(0, 1);
        if (!allow_illegal && mem_read) mem_write = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_output();
    endtask

    task automatic load_only();
        stall = 0; flush = 0; in_valid = 1;
    endtask

    initial begin
        reset = 1;
        apply_stimulus(0);
        #3;
        $display("[TB] reset state");
        model_reset();
        check_output();
        #4 reset = 0;

        $display("[TB] shift select");
        apply_stimulus(0); load_only();
        res_sel = 1; shift_sel = 2'b11; arith_right = 32'hF800_0000;
        dest_reg = 5; reg_write = 1;
        tick();
        check_val("shift_sel_result", ex_result, 32'hF800_0000);
        check_val("shift_sel_valid", out_valid, 1);
        check_val("shift_sel_fwd", fwd_en, 1);

        $display("[TB] stall hold");
        apply_stimulus(0); load_only();
        res_sel = 0; alu_result = 32'h1234; mem_read = 0; mem_write = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0); stall = 1; flush = 0;
            tick();
            check_val("stall_hold", ex_result, 32'h1234);
        end
`ifdef PERF_CNT_EN
        check_val("stall_cnt_3", stall_cnt, 3);
`endif

        $display("[TB] flush over stall");
        apply_stimulus(0); stall = 1; flush = 1;
        tick();
        check_val("flush_valid", out_valid, 0);
        check_val("flush_mem_write", out_mem_write, 0);
`ifdef PERF_CNT_EN
        check_val("flush_cnt", stall_cnt, 3);
`endif

        $display("[TB] zero register suppression");
        apply_stimulus(0); load_only();
        dest_reg = 0; reg_write = 1;
        tick();
        check_val("zero_reg_write", out_reg_write, 0);
        check_val("zero_fwd", fwd_en, 0);
        check_val("zero_valid", out_valid, 1);

        $display("[TB] illegal controls");
        apply_stimulus(0); load_only();
        mem_read = 1; mem_write = 1;
        tick();
        check_val("illegal_valid", out_valid, 0);
        check_val("illegal_flag", illegal_op, 1);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0); load_only();
            tick();
            check_val("illegal_sticky", illegal_op, 1);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1);
            tick();
        end

        $display("[TB] async reset");
        apply_stimulus(0); load_only();
        tick();
        #2 reset = 1;
        #1;
        model_reset();
        check_output();
        check_val("async_valid", out_valid, 0);
        #3 reset = 0;

        $display("[TB] reset during stall");
        apply_stimulus(0); load_only();
        tick();
        apply_stimulus(0); stall = 1; flush = 0;
        tick();
        #2 reset = 1;
        #1;
        model_reset();
        check_output();
        #2 reset = 0;
        apply_stimulus(0); load_only();
        tick();
        check_val("post_reset_load", out_valid, 1);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
